// File: rtl/cache_victim_sel.sv
// cache_victim_sel
//   Replacement-state block for the instruction and data caches. It keeps
//   per-set tree pseudo-LRU or round-robin state, or one global LFSR. It
//   produces the one-hot way to evict on a line fill.
//   Invalid ways win over the policy way. Locked ways are skipped.
//   An update and a read of the same set in one cycle are bypassed, so the
//   read register sees the updated state.
//
// Optional feature macro: CACHE_WAY_LOCK_EN
//   defined   : LockWay removes ways from victim choice. If every way is
//               locked, all ways are eligible again.
//   undefined : LockWay is ignored. The port is kept so the interface does
//               not change between builds.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   CacheEn           load the read register (CurState) from CacheSetTag
//   FlushStage        suppress the state update this cycle
//   LRUWriteEn        commit an access/fill update at PAdrSet
//   SetValid          update is a fill; the accessed way is VictimWay
//   InvalidateCache   clear all per-set state and CurState (not the LFSR)
//   HitWay            one-hot hit way
//   ValidWay          valid bits of the set being read
//   LockWay           ways excluded from victim choice
//   CacheSetTag       set index for the state read
//   PAdrSet           set index for the state update
//   VictimWay         one-hot victim way (combinational from CurState)

module cache_victim_sel #(
   parameter int NUMWAYS      = 4,
   parameter int NUMLINES     = 64,
   parameter int SETLEN       = 6,
   parameter int REPLACE_MODE = 0,   // 0 tree PLRU, 1 round-robin, 2 LFSR
   parameter int LFSRLEN      = 8    // 2..16, must be >= log2(NUMWAYS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                CacheEn,
   input  logic                FlushStage,
   input  logic                LRUWriteEn,
   input  logic                SetValid,
   input  logic                InvalidateCache,
   input  logic [NUMWAYS-1:0]  HitWay,
   input  logic [NUMWAYS-1:0]  ValidWay,
   input  logic [NUMWAYS-1:0]  LockWay,
   input  logic [SETLEN-1:0]   CacheSetTag,
   input  logic [SETLEN-1:0]   PAdrSet,
   output logic [NUMWAYS-1:0]  VictimWay
);

   localparam int LOGW = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;
   localparam int STW  = (REPLACE_MODE == 1) ? LOGW : ((NUMWAYS > 1) ? NUMWAYS - 1 : 1);

   // Maximal-length Fibonacci tap masks (bit n-1 set for tap n).
   function automatic logic [31:0] lfsr_taps(input int len);
      case (len)
         2:       return 32'h0003;
         3:       return 32'h0006;
         4:       return 32'h000C;
         5:       return 32'h0014;
         6:       return 32'h0030;
         7:       return 32'h0060;
         8:       return 32'h00B8;
         9:       return 32'h0110;
         10:      return 32'h0240;
         11:      return 32'h0500;
         12:      return 32'h0829;
         13:      return 32'h100D;
         14:      return 32'h2015;
         15:      return 32'h6000;
         16:      return 32'hD008;
         default: return 32'h00B8;
      endcase
   endfunction

   localparam logic [31:0] TAPS32 = lfsr_taps(LFSRLEN);

   generate
      if (NUMWAYS == 1) begin : g_one
         assign VictimWay = '1;
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clk, reset, CacheEn, FlushStage, LRUWriteEn, SetValid,
                                  InvalidateCache, HitWay, ValidWay, LockWay, CacheSetTag, PAdrSet};
      end else begin : g_multi
         logic [NUMWAYS-1:0] lock_eff;
         logic [NUMWAYS-1:0] elig;
         logic [NUMWAYS-1:0] inval_elig;
         logic [NUMWAYS-1:0] victim;
         logic [LOGW-1:0]    policy_idx;
         logic [LOGW-1:0]    pick_idx;
         logic [LOGW-1:0]    inval_idx;
         logic               found;

`ifdef CACHE_WAY_LOCK_EN
         assign lock_eff = LockWay;
`else
         assign lock_eff = '0;
         logic unused_lock;
         assign unused_lock = &{1'b0, LockWay};
`endif
         // Locking every way would leave nothing to evict, so fall back to all.
         assign elig       = (&lock_eff) ? '1 : ~lock_eff;
         assign inval_elig = elig & ~ValidWay;

         always_comb begin
            // First eligible way at or above the policy way, wrapping around.
            pick_idx = policy_idx;
            found    = 1'b0;
            for (int k = 0; k < NUMWAYS; k++) begin
               if (!found && elig[(int'(policy_idx) + k) % NUMWAYS]) begin
                  pick_idx = LOGW'((int'(policy_idx) + k) % NUMWAYS);
                  found    = 1'b1;
               end
            end
            // Lowest-index eligible invalid way: scan downward, last hit wins.
            inval_idx = '0;
            for (int k = NUMWAYS - 1; k >= 0; k--) begin
               if (inval_elig[k]) inval_idx = LOGW'(k);
            end
            victim = '0;
            if (|inval_elig) victim[inval_idx] = 1'b1;
            else             victim[pick_idx]  = 1'b1;
         end

         assign VictimWay = victim;

         if (REPLACE_MODE == 2) begin : g_rand
            logic [LFSRLEN-1:0] lfsr_q, lfsr_d;

            always_comb begin
               lfsr_d = lfsr_q;
               if (CacheEn) lfsr_d = {lfsr_q[LFSRLEN-2:0], ^(lfsr_q & TAPS32[LFSRLEN-1:0])};
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) lfsr_q <= LFSRLEN'(1);
               else       lfsr_q <= lfsr_d;
            end

            assign policy_idx = lfsr_q[LOGW-1:0];

            logic unused_rand;
            assign unused_rand = &{1'b0, FlushStage, LRUWriteEn, SetValid, InvalidateCache,
                                   HitWay, CacheSetTag, PAdrSet};
         end else begin : g_state
            logic [STW-1:0]     state_mem [NUMLINES];
            logic [STW-1:0]     cur_state_q, cur_state_d;
            logic [STW-1:0]     old_state, new_state;
            logic [NUMWAYS-1:0] acc_way;
            logic               upd_en;

            assign acc_way   = SetValid ? victim : HitWay;
            assign upd_en    = LRUWriteEn & ~FlushStage & (SetValid | (|HitWay));
            assign old_state = state_mem[PAdrSet];

            if (REPLACE_MODE == 0) begin : g_plru
               logic [LOGW-1:0] acc_idx;
               int              upd_node;
               int              walk_node;

               always_comb begin
                  acc_idx = '0;
                  for (int k = 0; k < NUMWAYS; k++) begin
                     if (acc_way[k]) acc_idx = LOGW'(k);
                  end
                  // Point every node on the accessed way's path away from it.
                  new_state = old_state;
                  upd_node  = 0;
                  for (int l = 0; l < LOGW; l++) begin
                     new_state[upd_node] = ~acc_idx[LOGW-1-l];
                     upd_node = 2 * upd_node + 1 + int'(acc_idx[LOGW-1-l]);
                  end
               end

               always_comb begin
                  policy_idx = '0;
                  walk_node  = 0;
                  for (int l = 0; l < LOGW; l++) begin
                     policy_idx[LOGW-1-l] = cur_state_q[walk_node];
                     walk_node = 2 * walk_node + 1 + int'(cur_state_q[walk_node]);
                  end
               end
            end else begin : g_rr
               // The counter only advances on fills; hits leave it alone.
               assign new_state  = SetValid ? old_state + STW'(1) : old_state;
               assign policy_idx = cur_state_q[LOGW-1:0];
            end

            always_comb begin
               cur_state_d = cur_state_q;
               if (InvalidateCache) begin
                  cur_state_d = '0;
               end else if (CacheEn) begin
                  if (upd_en && (CacheSetTag == PAdrSet)) cur_state_d = new_state;
                  else                                    cur_state_d = state_mem[CacheSetTag];
               end
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  cur_state_q <= '0;
                  for (int i = 0; i < NUMLINES; i++) state_mem[i] <= '0;
               end else begin
                  cur_state_q <= cur_state_d;
                  if (InvalidateCache) begin
                     for (int i = 0; i < NUMLINES; i++) state_mem[i] <= '0;
                  end else if (upd_en) begin
                     state_mem[PAdrSet] <= new_state;
                  end
               end
            end
         end
      end
   endgenerate

endmodule

// File: doc/cache_victim_sel.md
Name: cache_victim_sel

Overview:
- Parametrised replacement-state block for the I$ and D$; generalises the LRU and random victim selectors into one block.
- Supports three modes: tree pseudo-LRU, per-set round-robin, and global LFSR random.
- Gives priority to invalid ways, supports optional way locking, and bypasses same-set updates into the next read.
- Sits beside the cacheway array. Consumes HitWay/ValidWay and produces the one-hot VictimWay used on line fill.

Parameters:
- NUMWAYS, 4, ways per set; power of 2, 1..16.
- NUMLINES, 64, sets per way.
- SETLEN, 6, log2(NUMLINES).
- REPLACE_MODE, 0, 0 = tree PLRU, 1 = round-robin, 2 = LFSR random.
- LFSRLEN, 8, LFSR width (mode 2 only); taps fixed for maximal length.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- CacheEn  input  1  enables the replacement-state read register
- FlushStage  input  1  blocks state updates this cycle
- LRUWriteEn  input  1  commit access/fill update
- SetValid  input  1  this update is a line fill (use VictimWay)
- InvalidateCache  input  1  clear all replacement state
- HitWay  input  NUMWAYS  one-hot hit way
- ValidWay  input  NUMWAYS  valid bits of the read set
- LockWay  input  NUMWAYS  ways excluded from victim choice (see Optional Feature)
- CacheSetTag  input  SETLEN  set index for the state read
- PAdrSet  input  SETLEN  set index for the state update
- VictimWay  output  NUMWAYS  one-hot victim way

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- State storage: NUMLINES entries of per-set state.
  - PLRU: NUMWAYS-1 bits.
  - Round-robin: log2(NUMWAYS) bits.
  - Random: one global LFSRLEN-bit LFSR.
- Read latency:
  - When CacheEn=1, the state for CacheSetTag is registered (CurState).
  - VictimWay is combinational from CurState, ValidWay and LockWay, valid one cycle after the index is presented.
  - When CacheEn=0, CurState holds.
- Victim priority:
  - If any eligible way is invalid, VictimWay is the lowest-index eligible invalid way.
  - Otherwise VictimWay is the policy way.
  - Eligible = ~LockWay, unless all ways are locked, in which case all ways are eligible.
  - If the policy way is ineligible, select the next eligible way upward, wrapping at NUMWAYS.
- PLRU encoding:
  - Heap-ordered tree; node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Bit 0 steers to the lower half, bit 1 to the upper half.
  - Victim: walk from the root following the bits.
  - Access to way w: every node on w's path is set to point away from w.
- Round-robin: the policy way is the counter value. It increments modulo NUMWAYS only on a fill.
- Random: the policy way is LFSR[log2(NUMWAYS)-1:0]. The LFSR advances every cycle that CacheEn=1.
- Update:
  - Occurs when LRUWriteEn & ~FlushStage, at PAdrSet.
  - Accessed way = SetValid ? VictimWay : HitWay.
  - An update with HitWay=0 and SetValid=0 is ignored.
- Bypass: if an update and a read target the same set in the same cycle, CurState captures the updated value.
- InvalidateCache: the next edge clears all per-set state and CurState to 0; the LFSR is not cleared. InvalidateCache takes precedence over a simultaneous update.
- Reset values:
  - All state 0; LFSR = 1.
  - VictimWay = 1 (way 0) whenever way 0 is eligible. After reset this follows from invalid-priority or PLRU/RR state 0.
- Reset mid-update: reset wins and no write occurs.
- NUMWAYS=1: VictimWay is tied to 1 and no state is generated.

Optional Feature:
- CACHE_WAY_LOCK_EN defined: LockWay is honoured exactly as described in Victim priority.
- CACHE_WAY_LOCK_EN undefined: LockWay is ignored (treated as 0) and all ways are always eligible; the port remains for interface stability.

Test Plan:
- PLRU, NUMWAYS=4, reset, ValidWay=1111, set 5 -> VictimWay=0001. Hit on way0 -> next read of set 5 gives 0100. Hit on way2 -> 0010.
- ValidWay=1011 in any mode -> VictimWay=0100. ValidWay=0000 -> 0001.
- RR, set 3, four fills with SetValid=1, all valid -> victims 0001, 0010, 0100, 1000, then 0001. A fill in set 4 does not disturb set 3.
- Update at set 7 while reading set 7 in the same cycle -> next-cycle VictimWay reflects the update. FlushStage=1 during the update -> no change.
- InvalidateCache after scattered accesses -> all sets read state 0 (VictimWay=0001 when fully valid). Asserting reset mid-fill -> state 0 and LFSR=1.
- Lock enabled, PLRU state pointing at way0, LockWay=0001 -> VictimWay=0010. LockWay=1111 -> 0001. Macro undefined with LockWay=0001 -> 0001.
